isqrt_iter_fsm: RTL and testbench
=================================

ISQRT_ITER_FSM -- requirements
Module: isqrt_iter_fsm

Interface
REQ-001 SHALL have parameter: STEPS_PER_CYCLE, default 1, root bits resolved per clock; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: x_vld  input  1  request strobe; x valid this cycle.
REQ-005 SHALL have port: x  input  32  unsigned radicand.
REQ-006 SHALL have port: y_vld  output  1  one-cycle result strobe.
REQ-007 SHALL have port: y  output  16  unsigned floor(sqrt(x)).
REQ-008 SHALL have port: busy  output  1  high while a calculation is in progress.
REQ-009 SHALL have port: x_drop  output  1  one-cycle pulse: request ignored.

Function
REQ-010 SHALL compute y = floor(sqrt(x)) exactly for all 2^32 values of x; no rounding.
REQ-011 SHALL use the iterative digit-by-digit (two radicand bits per root bit, MSB first) method, with 18-bit remainder, 16-bit partial root and 32-bit shifted radicand registers.
REQ-012 SHALL implement states ST_IDLE, ST_CALC, ST_DONE; reset state ST_IDLE.
REQ-013 ST_IDLE: x_vld=1 -> capture x, clear remainder/root, set iteration counter to 16/STEPS_PER_CYCLE, go ST_CALC; x_vld=0 -> stay.
REQ-014 ST_CALC: each clock resolves STEPS_PER_CYCLE root bits and decrements the counter; on the edge resolving the last bit -> ST_DONE.
REQ-015 ST_DONE lasts exactly one cycle with y_vld=1; x_vld=1 in that cycle -> accept as in ST_IDLE and go ST_CALC (back-to-back); else -> ST_IDLE.
REQ-016 Latency: x_vld accepted in cycle 0 -> y_vld=1 in cycle 16/STEPS_PER_CYCLE+1 (17 for default), fixed, independent of x.
REQ-017 Throughput: one result per 16/STEPS_PER_CYCLE+1 cycles with requests issued in the ST_DONE cycle.
REQ-018 y_vld SHALL be a registered output, high only in ST_DONE.
REQ-019 y SHALL be registered, update on the edge entering ST_DONE, and hold until the next result; not cleared by a new request.
REQ-020 busy SHALL equal (state == ST_CALC), driven from the state register, no combinational path from x_vld.
REQ-021 x_vld=1 while in ST_CALC: request ignored, computation unaffected, x_drop=1 in the next cycle only.
REQ-022 x is sampled only on the accepting edge; changes to x during ST_CALC SHALL not affect the result.
REQ-023 No combinational path from any input to any output.

Reset
REQ-024 rst=1 SHALL asynchronously force state=ST_IDLE, y_vld=0, y=0, busy=0, x_drop=0, counter=0.
REQ-025 Reset during ST_CALC or ST_DONE SHALL discard the pending result; no y_vld after release until a new request completes.
REQ-026 x_vld in the first cycle after rst deassertion SHALL be accepted normally.

Verification
REQ-027 Boundaries, default parameter: x=0 -> y=0; x=1 -> y=1; x=15 -> y=3; x=16 -> y=4; x=0xFFFFFFFF -> y=0xFFFF; each y_vld in cycle 17 after acceptance, single cycle.
REQ-028 Back-to-back: x=16 in cycle 0, x=25 in y_vld cycle 17, x=36 in cycle 34 -> y=4 at cycle 17, y=5 at 34, y=6 at 51; busy low only in cycles 0, 17, 34, 51.
REQ-029 Dropped request: x=100 in cycle 0, x=49 in cycle 5 -> x_drop=1 in cycle 6 only; y=10 at cycle 17; no second y_vld.
REQ-030 Reset mid-operation: x=0x12345678 in cycle 0, rst pulse in cycle 8 (mid-cycle, asynchronous) -> outputs zero immediately, no y_vld; then x=81 -> y=9 17 cycles later.
REQ-031 STEPS_PER_CYCLE=4: x=0xFFFE0001 -> y=0xFFFF in cycle 5; x=0xFFFE0000 -> y=0xFFFE.
REQ-032 Random: 10^5 random x plus all perfect squares k^2 and k^2-1 (k = 1..65535), for each legal STEPS_PER_CYCLE, checked against a software floor(sqrt) model.

Source files
------------

// File: rtl/isqrt_iter_fsm_if.sv
// Request/result bundle for the iterative integer square-root unit.
// The requester drives x_vld/x; the unit returns y_vld/y plus busy/x_drop status.
interface isqrt_iter_fsm_if;
    logic        x_vld;
    logic [31:0] x;
    logic        y_vld;
    logic [15:0] y;
    logic        busy;
    logic        x_drop;

    modport master (
        output x_vld, x,
        input  y_vld, y, busy, x_drop
    );

    modport slave (
        input  x_vld, x,
        output y_vld, y, busy, x_drop
    );
endinterface

// File: rtl/isqrt_iter_fsm.sv
// Iterative floor(sqrt(x)) for 32-bit radicands, digit-by-digit, MSB first.
// Resolves STEPS_PER_CYCLE root bits per clock; fixed latency of 16/STEPS_PER_CYCLE+1 cycles.
module isqrt_iter_fsm #(
    parameter int unsigned STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    isqrt_iter_fsm_if.slave  bus
);

    localparam int unsigned ITERS = 16 / STEPS_PER_CYCLE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [17:0] rem_q;
    logic [15:0] root_q;
    logic [31:0] rad_q;
    logic [15:0] y_q;
    logic        y_vld_q;
    logic        x_drop_q;

    logic [17:0] rem_d;
    logic [15:0] root_d;
    logic [31:0] rad_d;
    logic [19:0] trial_rem;
    logic [19:0] trial_sub;

    // Unrolled restoring steps: bring down two radicand bits, try subtracting 4*root+1.
    // trial_rem can reach 19 bits before the compare, but every stored remainder fits in 17.
    always_comb begin
        rem_d     = rem_q;
        root_d    = root_q;
        rad_d     = rad_q;
        trial_rem = '0;
        trial_sub = '0;
        for (int unsigned i = 0; i < STEPS_PER_CYCLE; i++) begin
            trial_rem = {rem_d, rad_d[31:30]};
            trial_sub = {2'b00, root_d, 2'b01};
            if (trial_rem >= trial_sub) begin
                rem_d  = 18'(trial_rem - trial_sub);
                root_d = {root_d[14:0], 1'b1};
            end else begin
                rem_d  = 18'(trial_rem);
                root_d = {root_d[14:0], 1'b0};
            end
            rad_d = {rad_d[29:0], 2'b00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            rad_q    <= '0;
            y_q      <= '0;
            y_vld_q  <= 1'b0;
            x_drop_q <= 1'b0;
        end else begin
            y_vld_q  <= 1'b0;
            x_drop_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.x_vld) begin
                        rad_q   <= bus.x;
                        rem_q   <= '0;
                        root_q  <= '0;
                        cnt_q   <= 5'(ITERS);
                        state_q <= ST_CALC;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    rem_q    <= rem_d;
                    root_q   <= root_d;
                    rad_q    <= rad_d;
                    cnt_q    <= cnt_q - 5'd1;
                    x_drop_q <= bus.x_vld;
                    if (cnt_q == 5'd1) begin
                        y_q     <= root_d;
                        y_vld_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.y_vld  = y_vld_q;
    assign bus.y      = y_q;
    assign bus.busy   = (state_q == ST_CALC);
    assign bus.x_drop = x_drop_q;

endmodule

// File: tb/tb_isqrt_iter_fsm.sv
// Bench for isqrt_iter_fsm: five instances (1,2,4,8,16 steps/cycle) on shared stimulus,
// each compared every cycle against a latency-countdown model using a real-valued sqrt.
module tb_isqrt_iter_fsm;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        x_vld = 1'b0;
    logic [31:0] x     = '0;
    logic [31:0] k;
    int          cyc   = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    int          c0;

    logic        yv[5];
    logic [15:0] yy[5];
    logic        bz[5];
    logic        dr[5];
    logic        ev[5];
    logic [15:0] ey[5];
    logic        ebz[5];
    logic        edr[5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ref_isqrt(input logic [31:0] v);
        longint r;
        longint lv;
        lv = longint'(v);
        r  = longint'($sqrt(real'(lv)));
        while (r * r > lv) r--;
        while ((r + 1) * (r + 1) <= lv) r++;
        return r[15:0];
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 5; gi++) begin : g_dut
        localparam int S     = 1 << gi;
        localparam int ITERS = 16 / S;

        isqrt_iter_fsm_if bus ();

        int          t     = 0;
        logic        e_vld = 1'b0;
        logic        e_drop = 1'b0;
        logic [15:0] e_y   = '0;
        logic [31:0] px    = '0;

        assign bus.x_vld = x_vld;
        assign bus.x     = x;
        assign yv[gi]    = bus.y_vld;
        assign yy[gi]    = bus.y;
        assign bz[gi]    = bus.busy;
        assign dr[gi]    = bus.x_drop;
        assign ev[gi]    = e_vld;
        assign ey[gi]    = e_y;
        assign ebz[gi]   = (t != 0);
        assign edr[gi]   = e_drop;

        isqrt_iter_fsm #(
            .STEPS_PER_CYCLE(S)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );

        // t counts cycles still to wait for the result; 0 means free to accept.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                t      <= 0;
                e_vld  <= 1'b0;
                e_drop <= 1'b0;
                e_y    <= '0;
            end else begin
                e_vld  <= (t == 1);
                e_drop <= x_vld && (t != 0);
                if (t == 1) e_y <= ref_isqrt(px);
                if (x_vld && t == 0) begin
                    t  <= ITERS;
                    px <= x;
                end else if (t != 0) begin
                    t <= t - 1;
                end
            end
        end
    end

    initial begin
        #2;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("s%0d y_vld", 1 << i), yv[i], ev[i]);
                chk($sformatf("s%0d y", 1 << i), yy[i], ey[i]);
                chk($sformatf("s%0d busy", 1 << i), bz[i], ebz[i]);
                chk($sformatf("s%0d x_drop", 1 << i), dr[i], edr[i]);
            end
        end
    end

    task automatic wait_cycle(input int tgt);
        if (tgt < cyc) chk("schedule", cyc, tgt);
        while (cyc < tgt) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] v, output int acc);
        @(posedge clk);
        #1;
        x_vld = 1'b1;
        x     = v;
        acc   = cyc;
        @(posedge clk);
        #1;
        x_vld = 1'b0;
    endtask

    task automatic wait_res(input int acc, input logic [15:0] yexp, input string name);
        int got;
        got = -1;
        for (int i = 0; i < 40 && got < 0; i++) begin
            @(negedge clk);
            if (yv[0]) got = cyc;
        end
        chk({name, " latency"}, got - acc, 17);
        chk({name, " y"}, yy[0], yexp);
    endtask

    initial begin
        chk("ref 0", ref_isqrt(32'd0), 0);
        chk("ref 1", ref_isqrt(32'd1), 1);
        chk("ref 15", ref_isqrt(32'd15), 3);
        chk("ref 16", ref_isqrt(32'd16), 4);
        chk("ref max", ref_isqrt(32'hFFFF_FFFF), 16'hFFFF);
        chk("ref fffe0001", ref_isqrt(32'hFFFE_0001), 16'hFFFF);
        chk("ref fffe0000", ref_isqrt(32'hFFFE_0000), 16'hFFFE);

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset y_vld", yv[0], 0);
        chk("reset y", yy[0], 0);
        chk("reset busy", bz[0], 0);
        chk("reset x_drop", dr[0], 0);

        // Request already present in the first cycle after reset release.
        @(posedge clk);
        #1;
        x_vld = 1'b1;
        x     = 32'd0;
        c0    = cyc;
        #1 rst = 1'b0;
        @(posedge clk);
        #1 x_vld = 1'b0;
        wait_res(c0, 16'd0, "x=0");

        send(32'd1, c0);           wait_res(c0, 16'd1, "x=1");
        send(32'd15, c0);          wait_res(c0, 16'd3, "x=15");
        send(32'd16, c0);          wait_res(c0, 16'd4, "x=16");
        send(32'hFFFF_FFFF, c0);   wait_res(c0, 16'hFFFF, "x=max");

        // Back-to-back requests issued in the result cycle.
        send(32'd16, c0);
        wait_cycle(c0 + 17);
        x_vld = 1'b1;
        x     = 32'd25;
        @(negedge clk);
        chk("b2b vld 17", yv[0], 1);
        chk("b2b y 17", yy[0], 4);
        chk("b2b busy 17", bz[0], 0);
        wait_cycle(c0 + 18);
        x_vld = 1'b0;
        @(negedge clk);
        chk("b2b busy 18", bz[0], 1);
        wait_cycle(c0 + 34);
        x_vld = 1'b1;
        x     = 32'd36;
        @(negedge clk);
        chk("b2b vld 34", yv[0], 1);
        chk("b2b y 34", yy[0], 5);
        wait_cycle(c0 + 35);
        x_vld = 1'b0;
        wait_cycle(c0 + 51);
        @(negedge clk);
        chk("b2b vld 51", yv[0], 1);
        chk("b2b y 51", yy[0], 6);

        // Request during calculation is dropped.
        repeat (5) @(posedge clk);
        send(32'd100, c0);
        wait_cycle(c0 + 5);
        x_vld = 1'b1;
        x     = 32'd49;
        wait_cycle(c0 + 6);
        x_vld = 1'b0;
        @(negedge clk);
        chk("drop pulse", dr[0], 1);
        wait_cycle(c0 + 7);
        @(negedge clk);
        chk("drop single", dr[0], 0);
        wait_res(c0, 16'd10, "drop");
        repeat (20) @(posedge clk);

        // Asynchronous reset in the middle of a calculation.
        send(32'h1234_5678, c0);
        wait_cycle(c0 + 8);
        #1 rst = 1'b1;
        #1;
        chk("async rst y", yy[0], 0);
        chk("async rst busy", bz[0], 0);
        chk("async rst y_vld", yv[0], 0);
        #1 rst = 1'b0;
        repeat (25) @(posedge clk);
        send(32'd81, c0);
        wait_res(c0, 16'd9, "post-rst");

        // Four root bits per clock.
        repeat (3) @(posedge clk);
        send(32'hFFFE_0001, c0);
        wait_cycle(c0 + 5);
        x_vld = 1'b1;
        x     = 32'hFFFE_0000;
        @(negedge clk);
        chk("s4 vld a", yv[2], 1);
        chk("s4 y a", yy[2], 16'hFFFF);
        wait_cycle(c0 + 6);
        x_vld = 1'b0;
        wait_cycle(c0 + 10);
        @(negedge clk);
        chk("s4 vld b", yv[2], 1);
        chk("s4 y b", yy[2], 16'hFFFE);
        repeat (30) @(posedge clk);

        // Random radicands biased toward perfect squares and their predecessors.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            x_vld = ($urandom_range(0, 3) != 0);
            k     = 32'($urandom_range(1, 65535));
            case ($urandom_range(0, 2))
                0:       x = $urandom;
                1:       x = k * k;
                default: x = k * k - 32'd1;
            endcase
        end
        @(posedge clk);
        #1 x_vld = 1'b0;
        repeat (40) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
